// File: rtl/hms_timer_pkg.sv
// Shared types and constants for the hh:mm:ss countdown timer.
// Provides the controller state encoding, field limits and a zero-time helper.
package hms_timer_pkg;

    localparam int TIME_W = 6;

    localparam logic [TIME_W-1:0] SEC_MAX = TIME_W'(59);
    localparam logic [TIME_W-1:0] MIN_MAX = TIME_W'(59);
    localparam logic [TIME_W-1:0] HR_MAX  = TIME_W'(23);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic hms_is_zero(input logic [TIME_W-1:0] hh,
                                         input logic [TIME_W-1:0] mm,
                                         input logic [TIME_W-1:0] ss);
        return (hh == '0) && (mm == '0) && (ss == '0);
    endfunction

endpackage

// File: rtl/hms_countdown_timer_prescaler.sv
// One-second prescaler for the countdown timer.
// Counts clk cycles while enabled; tick is high for the single cycle in which
// the count sits at TICKS_PER_SEC-1, and the count wraps to 0 on that edge.
// The count holds while disabled, so a paused second resumes where it left off.
// Ports:
//   clk, reset (async, active-low)
//   enable : count this cycle
//   clr    : force the count to 0 (wins over enable)
//   tick   : one-cycle second strobe
module hms_prescaler #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int          PRESC_W       = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clr,
    output logic tick
);

    localparam logic [PRESC_W-1:0] TC = PRESC_W'(TICKS_PER_SEC - 1);

    logic [PRESC_W-1:0] cnt;

    assign tick = enable && (cnt == TC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/hms_countdown_timer.sv
// Hours/minutes/seconds countdown timer.
// Loaded with hh:mm:ss, counts down once per second and flags expiry at
// 00:00:00. Strobe priority within a cycle: clear > load > pause > start.
// Optional build macro HMS_COUNTDOWN_AUTO_RELOAD_EN: keep the last accepted
// load in a shadow and reload from it (staying in RUN) instead of expiring.
// Ports:
//   clk, reset (async, active-low)
//   load, ss_in/mm_in/hh_in : capture a new time (rejected if out of range)
//   start, pause, clear     : one-cycle control strobes
//   ss/mm/hh                : current time
//   running, expired        : registered state flags (RUN / DONE)
//   done_pulse              : one cycle on reaching 00:00:00
//   load_err                : one cycle when a load is rejected
//
// state  | meaning
// IDLE   | loaded or cleared, not counting
// RUN    | counting down, prescaler enabled
// PAUSED | frozen, prescaler holds its partial second
// DONE   | reached 00:00:00, waits for clear or load
module hms_countdown_timer
    import hms_timer_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int          PRESC_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [TIME_W-1:0] ss_in,
    input  logic [TIME_W-1:0] mm_in,
    input  logic [TIME_W-1:0] hh_in,
    input  logic              start,
    input  logic              pause,
    input  logic              clear,
    output logic [TIME_W-1:0] ss,
    output logic [TIME_W-1:0] mm,
    output logic [TIME_W-1:0] hh,
    output logic              running,
    output logic              expired,
    output logic              done_pulse,
    output logic              load_err
);

    state_t            state, state_n;
    logic [TIME_W-1:0] ss_n, mm_n, hh_n;
    logic [TIME_W-1:0] dec_ss, dec_mm, dec_hh;
    logic              done_n, err_n;
    logic              load_ok, counting, presc_clr, tick;

`ifdef HMS_COUNTDOWN_AUTO_RELOAD_EN
    logic [TIME_W-1:0] sh_ss, sh_mm, sh_hh;
    logic [TIME_W-1:0] sh_ss_n, sh_mm_n, sh_hh_n;
`endif

    assign load_ok = (ss_in <= SEC_MAX) && (mm_in <= MIN_MAX) && (hh_in <= HR_MAX);

    // Counting stops in any cycle where a higher-priority strobe changes state,
    // so a pause keeps the partial second intact.
    assign counting  = (state == RUN) && !clear && !(load && load_ok) && !pause;
    assign presc_clr = clear || (load && load_ok);

    hms_prescaler #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .PRESC_W       (PRESC_W)
    ) u_presc (
        .clk    (clk),
        .reset  (reset),
        .enable (counting),
        .clr    (presc_clr),
        .tick   (tick)
    );

    always_comb begin
        dec_ss = '0;
        dec_mm = '0;
        dec_hh = '0;
        if (ss != '0) begin
            dec_ss = ss - TIME_W'(1);
            dec_mm = mm;
            dec_hh = hh;
        end else if (mm != '0) begin
            dec_ss = SEC_MAX;
            dec_mm = mm - TIME_W'(1);
            dec_hh = hh;
        end else if (hh != '0) begin
            dec_ss = SEC_MAX;
            dec_mm = MIN_MAX;
            dec_hh = hh - TIME_W'(1);
        end
    end

    always_comb begin
        state_n = state;
        ss_n    = ss;
        mm_n    = mm;
        hh_n    = hh;
        done_n  = 1'b0;
        err_n   = 1'b0;
`ifdef HMS_COUNTDOWN_AUTO_RELOAD_EN
        sh_ss_n = sh_ss;
        sh_mm_n = sh_mm;
        sh_hh_n = sh_hh;
`endif
        if (counting && tick) begin
            if (hms_is_zero(dec_hh, dec_mm, dec_ss)) begin
                done_n = 1'b1;
`ifdef HMS_COUNTDOWN_AUTO_RELOAD_EN
                if (!hms_is_zero(sh_hh, sh_mm, sh_ss)) begin
                    ss_n = sh_ss;
                    mm_n = sh_mm;
                    hh_n = sh_hh;
                end else begin
                    ss_n    = '0;
                    mm_n    = '0;
                    hh_n    = '0;
                    state_n = DONE;
                end
`else
                ss_n    = '0;
                mm_n    = '0;
                hh_n    = '0;
                state_n = DONE;
`endif
            end else begin
                ss_n = dec_ss;
                mm_n = dec_mm;
                hh_n = dec_hh;
            end
        end

        if (clear) begin
            ss_n    = '0;
            mm_n    = '0;
            hh_n    = '0;
            state_n = IDLE;
`ifdef HMS_COUNTDOWN_AUTO_RELOAD_EN
            sh_ss_n = '0;
            sh_mm_n = '0;
            sh_hh_n = '0;
`endif
        end else if (load) begin
            if (load_ok) begin
                ss_n    = ss_in;
                mm_n    = mm_in;
                hh_n    = hh_in;
                state_n = IDLE;
`ifdef HMS_COUNTDOWN_AUTO_RELOAD_EN
                sh_ss_n = ss_in;
                sh_mm_n = mm_in;
                sh_hh_n = hh_in;
`endif
            end else begin
                err_n = 1'b1;
            end
        end else if (pause) begin
            if (state == RUN) state_n = PAUSED;
        end else if (start && (state == IDLE || state == PAUSED)) begin
            if (hms_is_zero(hh, mm, ss)) begin
                state_n = DONE;
                done_n  = 1'b1;
            end else begin
                state_n = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ss         <= '0;
            mm         <= '0;
            hh         <= '0;
            running    <= 1'b0;
            expired    <= 1'b0;
            done_pulse <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state      <= state_n;
            ss         <= ss_n;
            mm         <= mm_n;
            hh         <= hh_n;
            running    <= (state_n == RUN);
            expired    <= (state_n == DONE);
            done_pulse <= done_n;
            load_err   <= err_n;
        end
    end

`ifdef HMS_COUNTDOWN_AUTO_RELOAD_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_ss <= '0;
            sh_mm <= '0;
            sh_hh <= '0;
        end else begin
            sh_ss <= sh_ss_n;
            sh_mm <= sh_mm_n;
            sh_hh <= sh_hh_n;
        end
    end
`endif

endmodule

// File: tb/tb_hms_countdown_timer.sv
// Directed bench for hms_countdown_timer with a 4-cycle second.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_hms_countdown_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
    logic [5:0] ss_in = '0, mm_in = '0, hh_in = '0;
    logic [5:0] ss, mm, hh;
    logic       running, expired, done_pulse, load_err;

    int checks = 0;
    int errors = 0;
    int exp_expired;

    always #5 clk = ~clk;

    hms_countdown_timer #(.TICKS_PER_SEC(4), .PRESC_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .ss_in      (ss_in),
        .mm_in      (mm_in),
        .hh_in      (hh_in),
        .start      (start),
        .pause      (pause),
        .clear      (clear),
        .ss         (ss),
        .mm         (mm),
        .hh         (hh),
        .running    (running),
        .expired    (expired),
        .done_pulse (done_pulse),
        .load_err   (load_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] hms(input int h, input int m, input int s);
        return 32'(h * 4096 + m * 64 + s);
    endfunction

    function automatic logic [31:0] now_t();
        return {14'd0, hh, mm, ss};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input int h, input int m, input int s);
        hh_in = 6'(h); mm_in = 6'(m); ss_in = 6'(s);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        // reset state
        #3;
        check("rst_time", now_t(), hms(0, 0, 0));
        check("rst_running", running, 0);
        check("rst_expired", expired, 0);
        check("rst_done", done_pulse, 0);
        check("rst_err", load_err, 0);
        @(negedge clk);
        reset = 1'b1;
        cyc(1);

        // 1: basic countdown 00:01:02
        do_load(0, 1, 2);
        check("t1_load", now_t(), hms(0, 1, 2));
        check("t1_idle", running, 0);
        do_start();
        check("t1_running", running, 1);
        cyc(3);
        check("t1_not_early", now_t(), hms(0, 1, 2));
        cyc(1);
        check("t1_sec1", now_t(), hms(0, 1, 1));
        cyc(4);
        check("t1_sec2", now_t(), hms(0, 1, 0));
        cyc(4);
        check("t1_borrow_mm", now_t(), hms(0, 0, 59));
        check("t1_running2", running, 1);

        // 2: borrow across both fields
        do_load(1, 0, 0);
        check("t2_load_idle", running, 0);
        do_start();
        cyc(4);
        check("t2_borrow_hh", now_t(), hms(0, 59, 59));

`ifdef HMS_COUNTDOWN_AUTO_RELOAD_EN
        // 6: auto reload
        do_load(0, 0, 1);
        do_start();
        cyc(3);
        check("t6_done_early", done_pulse, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            check("t6_done", done_pulse, 1);
            check("t6_reload", now_t(), hms(0, 0, 1));
            check("t6_expired", expired, 0);
            check("t6_running", running, 1);
            cyc(1);
            check("t6_done_one", done_pulse, 0);
            cyc(2);
        end
        do_clear();
        exp_expired = 0;
`else
        // 3: expiry
        do_load(0, 0, 2);
        do_start();
        cyc(7);
        check("t3_pre", now_t(), hms(0, 0, 1));
        check("t3_done_early", done_pulse, 0);
        cyc(1);
        check("t3_zero", now_t(), hms(0, 0, 0));
        check("t3_done", done_pulse, 1);
        check("t3_expired", expired, 1);
        check("t3_run_off", running, 0);
        cyc(1);
        check("t3_done_one", done_pulse, 0);
        do_start();
        check("t3_start_ign", running, 0);
        check("t3_done_ign", done_pulse, 0);
        cyc(5);
        check("t3_hold", now_t(), hms(0, 0, 0));
        check("t3_expired2", expired, 1);
        exp_expired = 1;
`endif

        // 4: load range checks
        do_load(0, 0, 60);
        check("t4_err_ss", load_err, 1);
        check("t4_time_ss", now_t(), hms(0, 0, 0));
        check("t4_state_ss", expired, exp_expired);
        cyc(1);
        check("t4_err_pulse", load_err, 0);
        do_load(24, 0, 0);
        check("t4_err_hh", load_err, 1);
        check("t4_time_hh", now_t(), hms(0, 0, 0));
        do_load(0, 60, 0);
        check("t4_err_mm", load_err, 1);
        do_load(23, 59, 59);
        check("t4_accept", now_t(), hms(23, 59, 59));
        check("t4_accept_err", load_err, 0);
        check("t4_accept_exp", expired, 0);

        // 5: pause/resume keeps the partial second
        do_load(0, 0, 5);
        do_start();
        cyc(2);
        do_pause();
        check("t5_paused", running, 0);
        cyc(10);
        check("t5_frozen", now_t(), hms(0, 0, 5));
        do_start();
        check("t5_resumed", running, 1);
        cyc(1);
        check("t5_resume_pre", now_t(), hms(0, 0, 5));
        cyc(1);
        check("t5_resume_dec", now_t(), hms(0, 0, 4));

        // clear beats load and start in the same cycle
        hh_in = 6'd1; mm_in = 6'd2; ss_in = 6'd3;
        clear = 1'b1; load = 1'b1; start = 1'b1;
        @(negedge clk);
        clear = 1'b0; load = 1'b0; start = 1'b0;
        check("t5_clr_time", now_t(), hms(0, 0, 0));
        check("t5_clr_run", running, 0);
        check("t5_clr_exp", expired, 0);

        // async reset mid-run
        do_load(0, 0, 5);
        do_start();
        cyc(2);
        #2 reset = 1'b0;
        #1;
        check("t5_arst_time", now_t(), hms(0, 0, 0));
        check("t5_arst_run", running, 0);
        check("t5_arst_done", done_pulse, 0);
        @(negedge clk);
        reset = 1'b1;
        cyc(2);
        check("t5_arst_hold", now_t(), hms(0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hms_countdown_timer.md
Name: hms_countdown_timer

Overview:
- Hours/minutes/seconds countdown timer. It is the decrementing counterpart of the team's up-counting time-of-day clock.
- Loaded with hh:mm:ss, it counts down once per second, derived from an internal clk prescaler. It flags expiry at 00:00:00.
- Sits beside the time-of-day clock in the timekeeping subsystem and drives the same 6-bit hh/mm/ss display path.

Parameters:
- TICKS_PER_SEC, 50_000_000: clk cycles per one-second decrement; legal range 1 to 2^32-1.
- PRESC_W, 32: prescaler counter width; must satisfy 2^PRESC_W > TICKS_PER_SEC.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-low
- load  in  1  one-cycle strobe: capture ss_in/mm_in/hh_in
- ss_in  in  6  load seconds, legal 0..59
- mm_in  in  6  load minutes, legal 0..59
- hh_in  in  6  load hours, legal 0..23
- start  in  1  one-cycle strobe: begin or resume countdown
- pause  in  1  one-cycle strobe: freeze countdown
- clear  in  1  one-cycle strobe: zero time, return to IDLE
- ss  out  6  current seconds
- mm  out  6  current minutes
- hh  out  6  current hours
- running  out  1  high in RUN
- expired  out  1  level, high in DONE
- done_pulse  out  1  one-cycle pulse on entry to DONE
- load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (reset=0, asynchronous):
  - ss/mm/hh=0, prescaler=0, state=IDLE.
  - running, expired, done_pulse and load_err all 0.
- States: IDLE, RUN, PAUSED, DONE. All updates occur on the rising clk edge.
- Strobe priority within one cycle: clear > load > pause > start. Only the highest-priority asserted strobe acts.
- clear, any state: time=00:00:00, prescaler=0, next state IDLE.
- load, any state:
  - Accepted only if ss_in<=59, mm_in<=59 and hh_in<=23. Then time=inputs, prescaler=0, next state IDLE.
  - Otherwise time and state are unchanged and load_err pulses for 1 cycle.
- start:
  - From IDLE or PAUSED with time nonzero: next state RUN.
  - From IDLE or PAUSED with time zero: next state DONE, done_pulse fires.
  - In RUN or DONE: ignored.
- pause: from RUN, next state PAUSED and prescaler holds its value. Ignored in other states.
- Prescaler:
  - Increments only in RUN.
  - When it reaches TICKS_PER_SEC-1 it wraps to 0 and issues a second-strobe.
  - The first decrement happens TICKS_PER_SEC cycles after the start edge.
  - After a pause/start the prescaler resumes from its held value; no partial-second loss.
- Decrement on second-strobe:
  - If ss>0: ss-1.
  - Else if mm>0: ss=59, mm-1.
  - Else if hh>0: ss=59, mm=59, hh-1.
- If the decremented time is 00:00:00: on the same edge, next state DONE and done_pulse=1 for exactly one cycle.
- DONE: time held at 00:00:00 and expired=1. Leave only via clear or load.
- running is a registered function of state; expired likewise. Both are valid in the cycle after the transition edge.
- Outputs never leave legal ranges: ss and mm stay in 0..59, hh in 0..23.

Optional Feature:
- Macro: HMS_COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - The last accepted load value is kept in a shadow register; clear zeroes the shadow.
  - On reaching 00:00:00 from RUN, done_pulse fires, time reloads from the shadow on the same edge, and state stays RUN. The prescaler restarts at 0.
  - If the shadow is zero, behave as when the macro is undefined.
  - expired is never asserted while reloading.
- Undefined: no shadow register; behaviour is exactly as in Behaviour above.

Decomposition:
- Package hms_timer_pkg:
  - state enum {IDLE, RUN, PAUSED, DONE}.
  - Constants SEC_MAX=59, MIN_MAX=59, HR_MAX=23, TIME_W=6.
  - Function hms_is_zero(hh, mm, ss).
- Sub-module hms_prescaler:
  - Inputs enable, clr.
  - Output tick (one cycle).
  - Parameters TICKS_PER_SEC and PRESC_W.

Test Plan:
1. TICKS_PER_SEC=4. Load 00:01:02, start → ss decrements at 4, 8, 12 cycles after start; sequence 00:01:01, 00:01:00, 00:00:59. running=1 throughout.
2. Load 01:00:00, run one second → 00:59:59 (borrow across both fields).
3. Load 00:00:02, start → after 8 cycles time=00:00:00, done_pulse high exactly 1 cycle, expired=1 and stays 1. Further start strobes are ignored.
4. Load ss_in=60 → load_err pulse, time and state unchanged. Load hh_in=24 → same. Load 23:59:59 → accepted.
5. Run 00:00:05, pause 2 cycles into a second, hold 10 cycles, start → next decrement 2 cycles after resume. Assert clear+load+start in the same cycle → IDLE, 00:00:00. Assert reset mid-RUN → all outputs 0 immediately, with no clk edge needed.
6. With HMS_COUNTDOWN_AUTO_RELOAD_EN, load 00:00:01, start → done_pulse every 4 cycles, time returns to 00:00:01, expired stays 0.
